// File: rtl/backlight_spi_tx.sv
// Serial transmitter for the LED backlight driver: captures one dimming vector per frame,
// optionally smooths it with a per-block IIR, and shifts it out with SCLK/SDO and a latch strobe.
module backlight_spi_tx #(
  parameter int unsigned NUM_BLK   = 24,
  parameter int unsigned DW        = 8,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned IIR_SHIFT = 2
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iFrameStart,
  input  logic [NUM_BLK*DW-1:0] iBlockData,
  input  logic                  iFiltEn,
  output logic                  oSclk,
  output logic                  oSdo,
  output logic                  oLatch,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oOverrun
);

  localparam int unsigned BLK_W = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam int unsigned BIT_W = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILT  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ph_q, ph_d;
  logic             first_q, first_d;
  logic             filt_en_q, filt_en_d;

  logic sclk_q, sclk_d;
  logic sdo_q, sdo_d;
  logic latch_q, latch_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic ovr_q, ovr_d;

  logic [DW-1:0] x_q [NUM_BLK];
  logic [DW-1:0] y_q [NUM_BLK];

  logic              cap_en;
  logic              y_we;
  logic [DW-1:0]     x_sel, y_sel, y_filt, y_next;
  logic signed [DW:0] diff, step;

  // IIR step for the block currently addressed in FILT; result always lies between y and x
  always_comb begin
    x_sel  = x_q[blk_q];
    y_sel  = y_q[blk_q];
    diff   = $signed({1'b0, x_sel}) - $signed({1'b0, y_sel});
    step   = diff >>> IIR_SHIFT;
    y_filt = y_sel + step[DW-1:0];
    y_next = (filt_en_q && !first_q) ? y_filt : x_sel;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    bit_d     = bit_q;
    div_d     = div_q;
    ph_d      = ph_q;
    first_d   = first_q;
    filt_en_d = filt_en_q;
    cap_en    = 1'b0;
    y_we      = 1'b0;
    ovr_d     = iFrameStart && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (iFrameStart) begin
          cap_en    = 1'b1;
          filt_en_d = iFiltEn;
          blk_d     = '0;
          state_d   = S_FILT;
        end
      end
      S_FILT: begin
        y_we = 1'b1;
        if (blk_q == BLK_W'(NUM_BLK - 1)) begin
          first_d = 1'b0;
          blk_d   = '0;
          bit_d   = BIT_W'(DW - 1);
          div_d   = '0;
          ph_d    = 1'b0;
          state_d = S_SHIFT;
        end else begin
          blk_d = blk_q + BLK_W'(1);
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!ph_q) begin
            ph_d = 1'b1;
          end else begin
            ph_d = 1'b0;
            if (bit_q == '0) begin
              bit_d = BIT_W'(DW - 1);
              if (blk_q == BLK_W'(NUM_BLK - 1)) begin
                state_d = S_LATCH;
              end else begin
                blk_d = blk_q + BLK_W'(1);
              end
            end else begin
              bit_d = bit_q - BIT_W'(1);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LATCH: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = '0;
          state_d = S_DONE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // y[0] is never the block written on the FILT->SHIFT edge, so y_q is already current here
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    latch_d = (state_d == S_LATCH);
    sclk_d  = (state_d == S_SHIFT) && ph_d;
    sdo_d   = (state_d == S_SHIFT) ? y_q[blk_d][bit_d] : 1'b0;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      blk_q     <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      ph_q      <= 1'b0;
      first_q   <= 1'b1;
      filt_en_q <= 1'b0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      ph_q      <= ph_d;
      first_q   <= first_d;
      filt_en_q <= filt_en_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  // Captured input vector and filter history
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int unsigned k = 0; k < NUM_BLK; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      if (cap_en) begin
        for (int unsigned k = 0; k < NUM_BLK; k++) begin
          x_q[k] <= iBlockData[k*DW +: DW];
        end
      end
      if (y_we) begin
        y_q[blk_q] <= y_next;
      end
    end
  end

  assign oSclk    = sclk_q;
  assign oSdo     = sdo_q;
  assign oLatch   = latch_q;
  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oOverrun = ovr_q;

endmodule
